// File: rtl/gppcu_instr_dispatch_pkg.sv
// Shared types and default widths for the GPPCU instruction dispatcher.
package gppcu_instr_dispatch_pkg;

    localparam int unsigned DISP_DBW = 32;
    localparam int unsigned DISP_PBW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_e;

endpackage

// File: rtl/gppcu_instr_dispatch_if.sv
// Host, core and status signals of the instruction dispatcher, bundled for port hookup.
interface gppcu_instr_dispatch_if
    import gppcu_instr_dispatch_pkg::*;
#(
    parameter int unsigned DBW = DISP_DBW,
    parameter int unsigned PBW = DISP_PBW
);
    logic           iPROG_WR;
    logic [PBW-1:0] iPROG_ADDR;
    logic [DBW-1:0] iPROG_WDATA;
    logic           iSTART;
    logic [PBW:0]   iPROG_LEN;
    logic           oBUSY;
    logic           oDONE;
    logic [DBW-1:0] oINSTR;
    logic           oINSTR_VALID;
    logic           iINSTR_READY;
    logic           iCORE_IDLING;

    modport master (
        output iPROG_WR, iPROG_ADDR, iPROG_WDATA, iSTART, iPROG_LEN, iINSTR_READY, iCORE_IDLING,
        input  oBUSY, oDONE, oINSTR, oINSTR_VALID
    );

    modport slave (
        input  iPROG_WR, iPROG_ADDR, iPROG_WDATA, iSTART, iPROG_LEN, iINSTR_READY, iCORE_IDLING,
        output oBUSY, oDONE, oINSTR, oINSTR_VALID
    );
endinterface

// File: rtl/gppcu_dispatch_skid.sv
// Two-entry skid buffer: registered output stage plus one overflow slot, valid/ready on both sides.
module gppcu_dispatch_skid #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [W-1:0] s_data_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o,
    output logic [1:0]   count_o
);
    logic         v0_q, v0_d, v1_q, v1_d;
    logic [W-1:0] b0_q, b0_d, b1_q, b1_d;
    logic         push, pop;

    assign s_ready_o = !v1_q;
    assign push      = s_valid_i && s_ready_o;
    assign pop       = v0_q && m_ready_i;

    // Entry 0 always drives the output; entry 1 only holds a word while the output stalls.
    always_comb begin
        v0_d = v0_q;
        v1_d = v1_q;
        b0_d = b0_q;
        b1_d = b1_q;
        if (pop) begin
            if (v1_q) begin
                b0_d = b1_q;
                v1_d = 1'b0;
            end else if (push) begin
                b0_d = s_data_i;
            end else begin
                v0_d = 1'b0;
            end
        end else if (push) begin
            if (!v0_q) begin
                b0_d = s_data_i;
                v0_d = 1'b1;
            end else begin
                b1_d = s_data_i;
                v1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            b0_q <= '0;
            b1_q <= '0;
        end else begin
            v0_q <= v0_d;
            v1_q <= v1_d;
            b0_q <= b0_d;
            b1_q <= b1_d;
        end
    end

    assign m_valid_o = v0_q;
    assign m_data_o  = b0_q;
    assign count_o   = {1'b0, v0_q} + {1'b0, v1_q};

endmodule

// File: rtl/gppcu_instr_dispatch.sv
// Streams LEN program words to the core through a skid buffer, then waits for the core to drain.
// Define GPPCU_DISPATCH_STALLCNT_EN to add the oSTALL_CNT back-pressure counter port.
module gppcu_instr_dispatch
    import gppcu_instr_dispatch_pkg::*;
#(
    parameter int unsigned DBW = DISP_DBW,
    parameter int unsigned PBW = DISP_PBW
) (
    input  logic iACLK,
    input  logic inRST,
    gppcu_instr_dispatch_if.slave bus
`ifdef GPPCU_DISPATCH_STALLCNT_EN
    ,
    output logic [31:0] oSTALL_CNT
`endif
);
    localparam int unsigned   LW      = PBW + 1;
    localparam int unsigned   WORDS   = 1 << PBW;
    localparam logic [LW-1:0] MAX_LEN = LW'(WORDS);

    disp_state_e    state_q, state_d;
    logic [LW-1:0]  pc_q, pc_d, len_q, len_d, rem_q, rem_d;
    logic           idle_seen_q, idle_seen_d;
    logic           busy_q, done_q;
    logic           rd_en, rd_vld_q;
    logic [DBW-1:0] rd_data_q;
    logic [DBW-1:0] mem_q [WORDS];
    logic [LW-1:0]  start_len;
    logic           start_ok, xfer;
    logic           skid_s_ready, skid_m_valid;
    logic [DBW-1:0] skid_m_data;
    logic [1:0]     skid_count, in_flight;

    assign start_ok  = (state_q == ST_IDLE) && bus.iSTART;
    assign start_len = (bus.iPROG_LEN > MAX_LEN) ? MAX_LEN : bus.iPROG_LEN;
    assign xfer      = skid_m_valid && bus.iINSTR_READY;
    // Words already fetched that will still be untransferred after this edge.
    assign in_flight = skid_count + {1'b0, rd_vld_q} - {1'b0, xfer};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        rem_d       = rem_q;
        idle_seen_d = idle_seen_q;
        rd_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    len_d       = start_len;
                    rem_d       = start_len;
                    pc_d        = '0;
                    idle_seen_d = 1'b0;
                    state_d     = (start_len == '0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_en = (pc_q < len_q) && (in_flight < 2'd2);
                if (rd_en) pc_d = pc_q + LW'(1);
                if (xfer) begin
                    rem_d = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_d     = ST_DRAIN;
                        idle_seen_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.iCORE_IDLING) begin
                    if (idle_seen_q) state_d = ST_DONE;
                    else             idle_seen_d = 1'b1;
                end else begin
                    idle_seen_d = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            idle_seen_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            idle_seen_q <= idle_seen_d;
            busy_q      <= (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
            done_q      <= (state_d == ST_DONE);
            rd_vld_q    <= rd_en;
        end
    end

    // Program store: host writes only while idle, synchronous read, contents survive reset.
    always_ff @(posedge iACLK) begin
        if (bus.iPROG_WR && (state_q == ST_IDLE)) mem_q[bus.iPROG_ADDR] <= bus.iPROG_WDATA;
        if (rd_en) rd_data_q <= mem_q[pc_q[PBW-1:0]];
    end

    gppcu_dispatch_skid #(.W(DBW)) u_skid (
        .clk_i     (iACLK),
        .rst_ni    (inRST),
        .s_valid_i (rd_vld_q),
        .s_ready_o (skid_s_ready),
        .s_data_i  (rd_data_q),
        .m_valid_o (skid_m_valid),
        .m_ready_i (bus.iINSTR_READY),
        .m_data_o  (skid_m_data),
        .count_o   (skid_count)
    );

    // Read issue is throttled so returning data always finds a free skid slot.
    assert property (@(posedge iACLK) disable iff (!inRST) rd_vld_q |-> skid_s_ready);

    assign bus.oBUSY        = busy_q;
    assign bus.oDONE        = done_q;
    assign bus.oINSTR       = skid_m_data;
    assign bus.oINSTR_VALID = skid_m_valid;

`ifdef GPPCU_DISPATCH_STALLCNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if ((state_q == ST_ISSUE) && skid_m_valid && !bus.iINSTR_READY && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign oSTALL_CNT = stall_q;
`else
    // Stall counter not built; dispatch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_gppcu_instr_dispatch.sv
// Directed self-checking bench for gppcu_instr_dispatch (optionally with GPPCU_DISPATCH_STALLCNT_EN).
module tb_gppcu_instr_dispatch;
    localparam int unsigned DBW = 32;
    localparam int unsigned PBW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    gppcu_instr_dispatch_if #(.DBW(DBW), .PBW(PBW)) bus ();

`ifdef GPPCU_DISPATCH_STALLCNT_EN
    logic [31:0] stall_cnt;
`endif

    gppcu_instr_dispatch #(.DBW(DBW), .PBW(PBW)) dut (
        .iACLK (clk),
        .inRST (rst_n),
        .bus   (bus)
`ifdef GPPCU_DISPATCH_STALLCNT_EN
        ,
        .oSTALL_CNT (stall_cnt)
`endif
    );

    // {BUSY, DONE, VALID}
    function automatic logic [2:0] flags();
        return {bus.oBUSY, bus.oDONE, bus.oINSTR_VALID};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [PBW-1:0] a, input logic [DBW-1:0] d);
        bus.iPROG_WR    = 1'b1;
        bus.iPROG_ADDR  = a;
        bus.iPROG_WDATA = d;
        cyc();
        bus.iPROG_WR    = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 5; i++) host_write(PBW'(i), DBW'(32'h100 + i));
    endtask

    task automatic start(input logic [PBW:0] len);
        bus.iSTART    = 1'b1;
        bus.iPROG_LEN = len;
        cyc();
        bus.iSTART    = 1'b0;
    endtask

    task automatic test_reset();
        bus.iPROG_WR = 1'b0; bus.iPROG_ADDR = '0; bus.iPROG_WDATA = '0;
        bus.iSTART = 1'b0; bus.iPROG_LEN = '0;
        bus.iINSTR_READY = 1'b1; bus.iCORE_IDLING = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        total++; if (flags() !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", flags()); end
        total++; if (bus.oINSTR !== '0) begin bad++; $display("FAIL reset_instr got=%h want=0", bus.oINSTR); end
`ifdef GPPCU_DISPATCH_STALLCNT_EN
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
`endif
        @(negedge clk); rst_n = 1'b1;
        cyc();
        total++; if (flags() !== 3'b000) begin bad++; $display("FAIL reset_release got=%b want=000", flags()); end
    endtask

    task automatic test_ready_high();
        load_prog();
        bus.iINSTR_READY = 1'b1; bus.iCORE_IDLING = 1'b1;
        start(9'd5);
        total++; if (flags() !== 3'b100) begin bad++; $display("FAIL hi_c1 got=%b want=100", flags()); end
        cyc();
        total++; if (flags() !== 3'b100) begin bad++; $display("FAIL hi_c2 got=%b want=100", flags()); end
        cyc();
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.oINSTR_VALID !== 1'b1 || bus.oINSTR !== DBW'(32'h100 + k)) begin
                bad++; $display("FAIL hi_word%0d got=%b/%h want=1/%h", k, bus.oINSTR_VALID, bus.oINSTR, 32'h100 + k);
            end
            cyc();
        end
        total++; if (flags() !== 3'b100) begin bad++; $display("FAIL hi_drain got=%b want=100", flags()); end
        cyc();
        total++; if (flags() !== 3'b100) begin bad++; $display("FAIL hi_idle1 got=%b want=100", flags()); end
        cyc();
        total++; if (flags() !== 3'b010) begin bad++; $display("FAIL hi_done got=%b want=010", flags()); end
        cyc();
        total++; if (flags() !== 3'b000) begin bad++; $display("FAIL hi_idle got=%b want=000", flags()); end
    endtask

    task automatic test_ready_toggle();
        int idx = 0;
        int stalls = 0;
        int c = 0;
        bus.iCORE_IDLING = 1'b1;
        start(9'd5);
        while (idx < 5 && c < 40) begin
            bus.iINSTR_READY = (c % 3 == 0);
            total++;
            if (bus.oINSTR_VALID !== (c >= 2)) begin
                bad++; $display("FAIL tog_valid c=%0d got=%b want=%b", c, bus.oINSTR_VALID, c >= 2);
            end
            if (bus.oINSTR_VALID === 1'b1) begin
                total++;
                if (bus.oINSTR !== DBW'(32'h100 + idx)) begin
                    bad++; $display("FAIL tog_word c=%0d got=%h want=%h", c, bus.oINSTR, 32'h100 + idx);
                end
                if (bus.iINSTR_READY) idx++;
                else                  stalls++;
            end
            cyc();
            c++;
        end
        total++; if (idx != 5) begin bad++; $display("FAIL tog_count got=%0d want=5", idx); end
        total++; if (stalls != 9) begin bad++; $display("FAIL tog_stalls got=%0d want=9", stalls); end
`ifdef GPPCU_DISPATCH_STALLCNT_EN
        total++; if (stall_cnt !== 32'd9) begin bad++; $display("FAIL tog_stall_cnt got=%0d want=9", stall_cnt); end
`endif
        bus.iINSTR_READY = 1'b1;
        cyc(); cyc();
        total++; if (flags() !== 3'b010) begin bad++; $display("FAIL tog_done got=%b want=010", flags()); end
        cyc();
    endtask

    task automatic test_len_zero();
        bus.iINSTR_READY = 1'b1; bus.iCORE_IDLING = 1'b1;
        start(9'd0);
        total++; if (flags() !== 3'b100) begin bad++; $display("FAIL zl_drain got=%b want=100", flags()); end
        cyc();
        total++; if (flags() !== 3'b100) begin bad++; $display("FAIL zl_idle1 got=%b want=100", flags()); end
        cyc();
        total++; if (flags() !== 3'b010) begin bad++; $display("FAIL zl_done got=%b want=010", flags()); end
        cyc();
        total++; if (flags() !== 3'b000) begin bad++; $display("FAIL zl_idle got=%b want=000", flags()); end
    endtask

    task automatic test_idle_late();
        bus.iINSTR_READY = 1'b1; bus.iCORE_IDLING = 1'b0;
        start(9'd5);
        repeat (7) cyc();
        for (int i = 0; i < 10; i++) begin
            total++; if (flags() !== 3'b100) begin bad++; $display("FAIL late_wait%0d got=%b want=100", i, flags()); end
            cyc();
        end
        bus.iCORE_IDLING = 1'b1;
        cyc();
        total++; if (flags() !== 3'b100) begin bad++; $display("FAIL late_idle1 got=%b want=100", flags()); end
        cyc();
        total++; if (flags() !== 3'b010) begin bad++; $display("FAIL late_done got=%b want=010", flags()); end
        cyc();
    endtask

    task automatic test_ignored();
        bus.iINSTR_READY = 1'b1; bus.iCORE_IDLING = 1'b1;
        start(9'd5);
        cyc();
        bus.iSTART = 1'b1; bus.iPROG_LEN = 9'd3;
        bus.iPROG_WR = 1'b1; bus.iPROG_ADDR = 8'd4; bus.iPROG_WDATA = 32'hDEAD_BEEF;
        cyc();
        bus.iSTART = 1'b0; bus.iPROG_WR = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.oINSTR_VALID !== 1'b1 || bus.oINSTR !== DBW'(32'h100 + k)) begin
                bad++; $display("FAIL ign_word%0d got=%b/%h want=1/%h", k, bus.oINSTR_VALID, bus.oINSTR, 32'h100 + k);
            end
            cyc();
        end
        total++; if (flags() !== 3'b100) begin bad++; $display("FAIL ign_drain got=%b want=100", flags()); end
        cyc(); cyc();
        total++; if (flags() !== 3'b010) begin bad++; $display("FAIL ign_done got=%b want=010", flags()); end
        cyc();
    endtask

    task automatic test_same_edge();
        bus.iINSTR_READY = 1'b1; bus.iCORE_IDLING = 1'b1;
        bus.iPROG_WR = 1'b1; bus.iPROG_ADDR = 8'd0; bus.iPROG_WDATA = 32'h0000_0200;
        start(9'd1);
        bus.iPROG_WR = 1'b0;
        cyc();
        cyc();
        total++;
        if (bus.oINSTR_VALID !== 1'b1 || bus.oINSTR !== 32'h0000_0200) begin
            bad++; $display("FAIL same_word got=%b/%h want=1/00000200", bus.oINSTR_VALID, bus.oINSTR);
        end
        cyc(); cyc(); cyc();
        total++; if (flags() !== 3'b010) begin bad++; $display("FAIL same_done got=%b want=010", flags()); end
        cyc();
    endtask

    task automatic test_saturate();
        int n = 0;
        int budget = 0;
        for (int i = 0; i < 256; i++) host_write(PBW'(i), DBW'(32'h1000 + i));
        bus.iINSTR_READY = 1'b1; bus.iCORE_IDLING = 1'b1;
        start(9'h1FF);
        while (bus.oBUSY === 1'b1 && budget < 400) begin
            if (bus.oINSTR_VALID === 1'b1) begin
                total++;
                if (bus.oINSTR !== DBW'(32'h1000 + n)) begin
                    bad++; $display("FAIL sat_word%0d got=%h want=%h", n, bus.oINSTR, 32'h1000 + n);
                end
                n++;
            end
            cyc();
            budget++;
        end
        total++; if (n != 256) begin bad++; $display("FAIL sat_count got=%0d want=256", n); end
        total++; if (flags() !== 3'b010) begin bad++; $display("FAIL sat_done got=%b want=010", flags()); end
        cyc();
    endtask

    task automatic test_midrun_reset();
        load_prog();
        bus.iINSTR_READY = 1'b0; bus.iCORE_IDLING = 1'b1;
        start(9'd5);
        cyc(); cyc();
        total++; if (flags() !== 3'b101) begin bad++; $display("FAIL mr_pre got=%b want=101", flags()); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (flags() !== 3'b000) begin bad++; $display("FAIL mr_async got=%b want=000", flags()); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.iINSTR_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            total++; if (flags() !== 3'b000) begin bad++; $display("FAIL mr_after%0d got=%b want=000", i, flags()); end
        end
`ifdef GPPCU_DISPATCH_STALLCNT_EN
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL mr_stall got=%0d want=0", stall_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_ready_high();
        test_ready_toggle();
        test_len_zero();
        test_idle_late();
        test_ignored();
        test_same_edge();
        test_saturate();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gppcu_instr_dispatch.md
GPPCU_INSTR_DISPATCH -- requirements
Module: gppcu_instr_dispatch

Interface
REQ-001 Parameter DBW, default 32, instruction word width in bits.
REQ-002 Parameter PBW, default 8, program address width; program depth is 2^PBW words.
REQ-003 iACLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 inRST  in  1  reset, asynchronous and active-low.
REQ-005 iPROG_WR  in  1  host write strobe into the program memory.
REQ-006 iPROG_ADDR  in  PBW  host write address.
REQ-007 iPROG_WDATA  in  DBW  host write data.
REQ-008 iSTART  in  1  one-cycle run request.
REQ-009 iPROG_LEN  in  PBW+1  number of instructions to issue, sampled with iSTART.
REQ-010 oBUSY  out  1  high from an accepted iSTART until oDONE.
REQ-011 oDONE  out  1  one-cycle pulse at end of run.
REQ-012 oINSTR  out  DBW  instruction to core.
REQ-013 oINSTR_VALID  out  1  oINSTR is valid.
REQ-014 iINSTR_READY  in  1  core accepts the instruction this edge.
REQ-015 iCORE_IDLING  in  1  core pipeline empty.

Function
REQ-016 States are IDLE, ISSUE, DRAIN and DONE; reset state is IDLE.
REQ-017 In IDLE, iSTART latches iPROG_LEN into a remaining count and clears the read PC to 0; the next state is ISSUE, or DRAIN when the length is 0.
REQ-018 In any state other than IDLE, iSTART shall be ignored.
REQ-019 The program memory is a synchronous read with 1-cycle latency; a 2-entry skid buffer sits between the memory and oINSTR.
REQ-020 A transfer occurs on an edge where oINSTR_VALID and iINSTR_READY are both high.
REQ-021 While oINSTR_VALID is high and iINSTR_READY is low, oINSTR and oINSTR_VALID shall hold stable.
REQ-022 oINSTR_VALID shall not depend combinationally on iINSTR_READY.
REQ-023 The first oINSTR_VALID shall rise exactly 2 cycles after the iSTART edge.
REQ-024 With iINSTR_READY held high, the block shall sustain one transfer per cycle with no bubbles.
REQ-025 Memory reads are issued only while fetched-but-untransferred words are fewer than 2 and PC is less than the latched length.
REQ-026 Exactly the latched length of words is transferred, in address order 0..LEN-1.
REQ-027 After the last transfer the state becomes DRAIN, and oINSTR_VALID is low.
REQ-028 DRAIN exits to DONE after iCORE_IDLING has been sampled high on 2 consecutive edges.
REQ-029 DONE lasts one cycle with oDONE high, then goes to IDLE.
REQ-030 oBUSY is high in ISSUE and DRAIN, and low in IDLE and DONE.
REQ-031 Host writes are performed only in IDLE; writes in other states shall be dropped.
REQ-032 A host write and iSTART on the same IDLE edge: the write is performed and the run reads the new data.
REQ-033 iPROG_LEN above 2^PBW is saturated to 2^PBW.

Reset
REQ-034 While inRST is low: state is IDLE, PC and count are 0, the skid buffer is empty, and oINSTR_VALID, oBUSY and oDONE are 0, immediately and independent of iACLK.
REQ-035 oINSTR resets to 0.
REQ-036 Program memory contents are not reset.
REQ-037 A reset mid-run aborts the run with no oDONE pulse.

Configuration
REQ-038 With GPPCU_DISPATCH_STALLCNT_EN defined, the block adds output oSTALL_CNT [31:0].
REQ-039 oSTALL_CNT counts cycles in ISSUE where oINSTR_VALID is high and iINSTR_READY is low.
REQ-040 oSTALL_CNT clears on an accepted iSTART and on reset, and saturates at all-ones.
REQ-041 Without GPPCU_DISPATCH_STALLCNT_EN, neither the port nor its logic exists, and all other behaviour is identical.

Structure
REQ-042 A shared package holds the state encoding typedef (IDLE, ISSUE, DRAIN, DONE) and the default DBW and PBW constants.
REQ-043 The skid buffer shall be the sub-module gppcu_dispatch_skid, with depth 2 and a valid/ready interface on both sides.
REQ-044 The program memory shall be inferred inline.

Verification
REQ-045 Load words 0x100..0x104 at addresses 0..4, iSTART with LEN=5, ready always high: the core sees 0x100..0x104 on 5 consecutive edges, with the first VALID 2 cycles after iSTART.
REQ-046 Same program, ready toggling 1,0,0,1,...: oINSTR is held during every low-ready cycle, the 5 words arrive in order, and with the macro defined oSTALL_CNT equals the number of low-ready cycles with VALID high.
REQ-047 LEN=0: no VALID is asserted, DRAIN is entered, and oDONE pulses once after 2 idling edges.
REQ-048 iCORE_IDLING held low for 10 cycles after the last transfer: oBUSY stays high, and oDONE pulses 2 cycles after idling rises.
REQ-049 iSTART and host writes during ISSUE: both are ignored, memory is unchanged, and the run completes normally.
REQ-050 inRST asserted mid-ISSUE with VALID high: VALID, BUSY and DONE drop immediately without a clock edge, and no oDONE pulse follows.
